// File: rtl/wb_uart_lite.sv
// Wishbone-slave UART with TX/RX FIFOs, runtime baud divisor and sticky W1C error flags.
// Optional parity support is compiled in when UART_PARITY_EN is defined.
module wb_uart_lite #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        int_o,
   output logic        stx_pad_o,
   input  logic        srx_pad_i
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      T_IDLE,
      T_START,
      T_DATA,
`ifdef UART_PARITY_EN
      T_PAR,
`endif
      T_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
`ifdef UART_PARITY_EN
      R_PAR,
`endif
      R_STOP,
      R_WAIT
   } rx_state_t;

   logic [1:0]  reg_sel;
   logic        acc, wr, rd, w1c;
   logic [31:0] rdata;
   logic        rx_irq_en, tx_irq_en, parity_odd;
   logic [15:0] divisor;
   logic        overrun, frame_err, parity_err;
   logic        set_ovr, set_fe, set_pe;
   logic        unused_bits;

   logic [AW:0]          txw, txr, rxw, rxr;
   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic                 tx_empty, tx_full, rx_empty, rx_full;
   logic                 tx_push, tx_pop, rx_push, rx_pop;

   tx_state_t            tx_state, tx_next;
   logic [15:0]          tx_cnt, tx_cnt_n, tx_div, tx_div_n;
   logic [3:0]           tx_bit, tx_bit_n;
   logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
   logic                 tx_load, tx_busy, tx_end;

   rx_state_t            rx_state, rx_next;
   logic                 rx_meta, rx_s, rx_prev;
   logic [15:0]          rx_cnt, rx_cnt_n, rx_div, rx_div_n;
   logic [3:0]           rx_bit, rx_bit_n;
   logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
   logic                 rx_end;

   assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};

   // Side effects only on the ack cycle, so a held strobe yields one access per ack.
   assign reg_sel = wb_adr_i[3:2];
   assign acc     = wb_cyc_i & wb_stb_i & wb_ack_o;
   assign wr      = acc & wb_we_i & wb_sel_i[0];
   assign rd      = acc & ~wb_we_i;
   assign w1c     = wr && (reg_sel == 2'd1);

   assign tx_empty = (txw == txr);
   assign tx_full  = (txw[AW] != txr[AW]) && (txw[AW-1:0] == txr[AW-1:0]);
   assign rx_empty = (rxw == rxr);
   assign rx_full  = (rxw[AW] != rxr[AW]) && (rxw[AW-1:0] == rxr[AW-1:0]);
   assign tx_push  = wr && (reg_sel == 2'd0) && (!tx_full || tx_pop);
   assign rx_pop   = rd && (reg_sel == 2'd0) && !rx_empty;
   assign tx_busy  = (tx_state != T_IDLE);

   always_ff @(posedge wb_clk_i) begin
      if (tx_push) tx_mem[txw[AW-1:0]] <= wb_dat_i[DATA_BITS-1:0];
      if (rx_push) rx_mem[rxw[AW-1:0]] <= rx_sh;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         txw <= '0; txr <= '0; rxw <= '0; rxr <= '0;
      end else begin
         if (tx_push) txw <= txw + 1'b1;
         if (tx_pop)  txr <= txr + 1'b1;
         if (rx_push) rxw <= rxw + 1'b1;
         if (rx_pop)  rxr <= rxr + 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o  <= 1'b0;
         int_o     <= 1'b0;
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
         divisor   <= 16'(CLKS_PER_BIT);
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
         int_o    <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
         if (wr && (reg_sel == 2'd2)) begin
            rx_irq_en <= wb_dat_i[0];
            tx_irq_en <= wb_dat_i[1];
         end
         if (wr && (reg_sel == 2'd3))
            divisor <= (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
         if (set_ovr) overrun <= 1'b1;
         else if (w1c && wb_dat_i[4]) overrun <= 1'b0;
         if (set_fe) frame_err <= 1'b1;
         else if (w1c && wb_dat_i[5]) frame_err <= 1'b0;
      end
   end

`ifdef UART_PARITY_EN
   logic tx_par, tx_par_n, rx_perr, rx_perr_n;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         parity_odd <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (wr && (reg_sel == 2'd2)) parity_odd <= wb_dat_i[2];
         if (set_pe) parity_err <= 1'b1;
         else if (w1c && wb_dat_i[6]) parity_err <= 1'b0;
      end
   end
`else
   assign parity_odd = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (reg_sel)
         2'd0: if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem[rxr[AW-1:0]];
         2'd1: rdata[7:0] = {tx_busy, parity_err, frame_err, overrun,
                             tx_full, tx_empty, rx_full, rx_empty};
         2'd2: rdata[2:0] = {parity_odd, tx_irq_en, rx_irq_en};
         default: rdata[15:0] = divisor;
      endcase
   end

   assign wb_dat_o = wb_ack_o ? rdata : '0;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tx_state <= T_IDLE;
         tx_cnt   <= '0;
         tx_div   <= 16'(CLKS_PER_BIT);
         tx_bit   <= '0;
         tx_sh    <= '0;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_n;
         tx_div   <= tx_div_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
`ifdef UART_PARITY_EN
         tx_par   <= tx_par_n;
`endif
      end
   end

   assign tx_end = (tx_cnt == tx_div - 16'd1);

   always_comb begin
      tx_next  = tx_state;
      tx_cnt_n = tx_cnt + 16'd1;
      tx_div_n = tx_div;
      tx_bit_n = tx_bit;
      tx_sh_n  = tx_sh;
      tx_pop   = 1'b0;
      tx_load  = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_n = tx_par;
`endif
      case (tx_state)
         T_IDLE: begin
            tx_cnt_n = '0;
            tx_load  = !tx_empty;
         end
         T_START: if (tx_end) begin
            tx_cnt_n = '0;
            tx_bit_n = '0;
            tx_next  = T_DATA;
         end
         T_DATA: if (tx_end) begin
            tx_cnt_n = '0;
            tx_sh_n  = tx_sh >> 1;
            tx_bit_n = tx_bit + 4'd1;
`ifdef UART_PARITY_EN
            if (tx_bit == LAST_BIT) tx_next = T_PAR;
`else
            if (tx_bit == LAST_BIT) tx_next = T_STOP;
`endif
         end
`ifdef UART_PARITY_EN
         T_PAR: if (tx_end) begin
            tx_cnt_n = '0;
            tx_next  = T_STOP;
         end
`endif
         T_STOP: if (tx_end) begin
            tx_cnt_n = '0;
            tx_next  = T_IDLE;
            tx_load  = !tx_empty;
         end
         default: tx_next = T_IDLE;
      endcase
      // Frame start is shared by IDLE and end-of-STOP so frames can run back to back.
      if (tx_load) begin
         tx_pop   = 1'b1;
         tx_sh_n  = tx_mem[txr[AW-1:0]];
         tx_div_n = divisor;
         tx_cnt_n = '0;
         tx_next  = T_START;
`ifdef UART_PARITY_EN
         tx_par_n = (^tx_mem[txr[AW-1:0]]) ^ parity_odd;
`endif
      end
   end

   always_comb begin
      stx_pad_o = 1'b1;
      case (tx_state)
         T_START: stx_pad_o = 1'b0;
         T_DATA:  stx_pad_o = tx_sh[0];
`ifdef UART_PARITY_EN
         T_PAR:   stx_pad_o = tx_par;
`endif
         default: stx_pad_o = 1'b1;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
         rx_div   <= 16'(CLKS_PER_BIT);
         rx_bit   <= '0;
         rx_sh    <= '0;
`ifdef UART_PARITY_EN
         rx_perr  <= 1'b0;
`endif
      end else begin
         rx_meta  <= srx_pad_i;
         rx_s     <= rx_meta;
         rx_prev  <= rx_s;
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_n;
         rx_div   <= rx_div_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
`ifdef UART_PARITY_EN
         rx_perr  <= rx_perr_n;
`endif
      end
   end

   assign rx_end = (rx_cnt == rx_div - 16'd1);

   always_comb begin
      rx_next  = rx_state;
      rx_cnt_n = rx_cnt + 16'd1;
      rx_div_n = rx_div;
      rx_bit_n = rx_bit;
      rx_sh_n  = rx_sh;
      rx_push  = 1'b0;
      set_ovr  = 1'b0;
      set_fe   = 1'b0;
      set_pe   = 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_n = rx_perr;
`endif
      case (rx_state)
         R_IDLE: begin
            rx_cnt_n = '0;
            if (rx_prev && !rx_s) begin
               rx_div_n = divisor;
               rx_next  = R_START;
`ifdef UART_PARITY_EN
               rx_perr_n = 1'b0;
`endif
            end
         end
         R_START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
            rx_cnt_n = '0;
            rx_bit_n = '0;
            rx_next  = rx_s ? R_IDLE : R_DATA;
         end
         R_DATA: if (rx_end) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
            rx_bit_n = rx_bit + 4'd1;
`ifdef UART_PARITY_EN
            if (rx_bit == LAST_BIT) rx_next = R_PAR;
`else
            if (rx_bit == LAST_BIT) rx_next = R_STOP;
`endif
         end
`ifdef UART_PARITY_EN
         R_PAR: if (rx_end) begin
            rx_cnt_n  = '0;
            rx_perr_n = rx_s ^ (^rx_sh) ^ parity_odd;
            rx_next   = R_STOP;
         end
`endif
         R_STOP: if (rx_end) begin
            rx_cnt_n = '0;
            if (rx_s) begin
               if (rx_full && !rx_pop) set_ovr = 1'b1;
               else rx_push = 1'b1;
`ifdef UART_PARITY_EN
               set_pe = rx_perr;
`endif
               rx_next = R_IDLE;
            end else begin
               set_fe  = 1'b1;
               rx_next = R_WAIT;
            end
         end
         R_WAIT: if (rx_s) rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_uart_lite.sv
// Directed self-checking bench for wb_uart_lite; divisor 16, loopback via stx->srx.
// Parity checks are compiled in when UART_PARITY_EN is defined.
module tb_wb_uart_lite;

`ifdef UART_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  adr = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic [3:0]  sel = '0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic        ack, irq, stx, srx;
   logic        loop = 1'b0;
   logic        rx_drv = 1'b1;
   logic [3:0]  sel_val = 4'hF;
   logic [31:0] q;
   int unsigned checks = 0;
   int unsigned failures = 0;

   assign srx = loop ? stx : rx_drv;

   always #5 clk = ~clk;

   wb_uart_lite #(
      .DATA_BITS(8),
      .CLKS_PER_BIT(434),
      .FIFO_DEPTH(16)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wb_adr_i(adr),
      .wb_dat_i(dat_i),
      .wb_dat_o(dat_o),
      .wb_sel_i(sel),
      .wb_cyc_i(cyc),
      .wb_stb_i(stb),
      .wb_we_i(we),
      .wb_ack_o(ack),
      .int_o(irq),
      .stx_pad_o(stx),
      .srx_pad_i(srx)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [3:0] a, input logic [31:0] d, input logic w, output logic [31:0] r);
      bit got = 1'b0;
      r = '0;
      @(negedge clk);
      adr = a; dat_i = d; we = w; sel = sel_val; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            r = dat_o;
         end
      end
      if (!got) check_val("bus_ack", 32'(got), 32'd1);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(a, d, 1'b1, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus(a, 32'd0, 1'b0, r);
      check_val(tag, r, exp);
   endtask

   task automatic wait_tx_low(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (stx == 1'b0) seen = 1'b1;
      end
      if (!seen) check_val("tx_start_timeout", 32'(seen), 32'd1);
   endtask

   // Samples each bit centre of a 16-clk/bit frame, then STATUS while still in the stop bit.
   task automatic check_tx_frame(input logic [7:0] d);
      logic [10:0] fr;
      int n;
      bit seen;
      n = PAR ? 11 : 10;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[i+1] = d[i];
      if (PAR) fr[9] = ^d;
      wait_tx_low(seen);
      if (seen) begin
         wait_cyc(8);
         for (int k = 0; k < n; k++) begin
            check_val($sformatf("tx_bit%0d", k), 32'(stx), 32'(fr[k]));
            if (k < n - 1) wait_cyc(16);
         end
         rd_chk("tx_busy_in_stop", 4'h4, 32'h85);
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop_bit);
      @(negedge clk) rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (16) @(negedge clk);
      end
      if (PAR) begin
         rx_drv = ^d;
         repeat (16) @(negedge clk);
      end
      rx_drv = stop_bit;
      repeat (16) @(negedge clk);
      rx_drv = 1'b1;
      repeat (32) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_stx", 32'(stx), 32'd1);
      check_val("rst_ack", 32'(ack), 32'd0);
      check_val("rst_dat", dat_o, 32'd0);
      check_val("rst_int", 32'(irq), 32'd0);
      @(negedge clk) rst = 1'b0;

      rd_chk("rst_status", 4'h4, 32'h05);
      rd_chk("rst_ctrl", 4'h8, 32'h0);
      rd_chk("rst_div", 4'hC, 32'd434);
      rd_chk("rx_empty_read", 4'h0, 32'h0);

      wr(4'hC, 32'd2);
      rd_chk("div_min", 4'hC, 32'd4);
      wr(4'hC, 32'd16);
      rd_chk("div_16", 4'hC, 32'd16);
      sel_val = 4'hE;
      wr(4'hC, 32'd100);
      sel_val = 4'hF;
      rd_chk("sel0_ignored", 4'hC, 32'd16);
      wr(4'h8, 32'h7);
      rd_chk("ctrl_rw", 4'h8, PAR ? 32'h7 : 32'h3);
      wr(4'h8, 32'h0);

      wr(4'h0, 32'h55);
      check_tx_frame(8'h55);
      wait_cyc(20);
      rd_chk("tx_idle_status", 4'h4, 32'h05);

      wr(4'h8, 32'h2);
      wait_cyc(2);
      check_val("int_tx_idle", 32'(irq), 32'd1);
      wr(4'h0, 32'h81);
      wr(4'h0, 32'h42);
      wait_cyc(50);
      check_val("int_fifo_pending", 32'(irq), 32'd0);
      wait_cyc(150);
      check_val("int_fifo_drained", 32'(irq), 32'd1);
      wait_cyc(200);
      rd_chk("int_done_status", 4'h4, 32'h05);
      wr(4'h8, 32'h0);

      loop = 1'b1;
      wr(4'h0, 32'hA5);
      wr(4'h0, 32'h3C);
      wait_cyc(400);
      rd_chk("loop_status", 4'h4, 32'h04);
      rd_chk("loop_rx0", 4'h0, 32'hA5);
      rd_chk("loop_rx1", 4'h0, 32'h3C);
      rd_chk("loop_rx_empty", 4'h0, 32'h00);
      rd_chk("loop_status2", 4'h4, 32'h05);

      for (int i = 0; i < 17; i++) wr(4'h0, 32'h10 + 32'(i));
      wait_cyc(3200);
      rd_chk("ovr_status", 4'h4, 32'h16);
      wr(4'h4, 32'h10);
      rd_chk("ovr_cleared", 4'h4, 32'h06);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("ovr_rx%0d", i), 4'h0, 32'h10 + 32'(i));
      rd_chk("ovr_drained", 4'h4, 32'h05);
      loop = 1'b0;

      send_rx(8'h5A, 1'b0);
      rd_chk("ferr_status", 4'h4, 32'h25);
      wr(4'h4, 32'h20);
      rd_chk("ferr_cleared", 4'h4, 32'h05);
      send_rx(8'hC3, 1'b1);
      rd_chk("rx_direct", 4'h0, 32'hC3);

      @(negedge clk) rx_drv = 1'b0;
      @(negedge clk) rx_drv = 1'b1;
      wait_cyc(60);
      rd_chk("glitch_status", 4'h4, 32'h05);

`ifdef UART_PARITY_EN
      wr(4'h0, 32'h07);
      check_tx_frame(8'h07);
      wait_cyc(20);
      @(negedge clk) rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = (i < 3);
         repeat (16) @(negedge clk);
      end
      rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      rx_drv = 1'b1;
      repeat (48) @(negedge clk);
      rd_chk("perr_status", 4'h4, 32'h44);
      rd_chk("perr_byte", 4'h0, 32'h07);
      wr(4'h4, 32'h40);
      rd_chk("perr_cleared", 4'h4, 32'h05);
`endif

      wr(4'h0, 32'h00);
      wait_tx_low(seen);
      wait_cyc(30);
      check_val("midframe_low", 32'(stx), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check_val("midframe_rst_stx", 32'(stx), 32'd1);
      @(negedge clk) rst = 1'b0;
      rd_chk("post_rst_div", 4'hC, 32'd434);
      rd_chk("post_rst_status", 4'h4, 32'h05);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
